dht11_read_ctrl: RTL and testbench
==================================

Name: dht11_read_ctrl

Overview:
- Sequencer for the single-wire DHT11 temperature/humidity sensor bus.
- On a START request it:
  - drives the host start pulse;
  - checks the sensor's response preamble;
  - times and decodes the 40 data bits;
  - verifies the checksum;
  - publishes humidity and temperature registers for the display path.
- Enforces a mandatory hold-off between reads, so a free-running requester cannot over-poll the sensor.

Parameters:
- TICKS_PER_US, 8, pCLK cycles per microsecond tick (8 MHz system clock).
- START_LOW_US, 18000, duration the host holds the bus low.
- TIMEOUT_US, 100, maximum wait for any expected bus edge.
- BIT_THRESH_US, 40, high-phase length above which a bit decodes as 1.
- HOLDOFF_US, 1000000, idle time enforced after every read attempt.

Ports:
- pCLK  in  1  system clock, all logic on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- START  in  1  read request, sampled level; accepted only in IDLE.
- DATA_IN  in  1  bus level from the open-drain pad.
- DATA_OE  out  1  1 = pad drives bus low; 0 = released (pull-up).
- BUSY  out  1  high from START acceptance until HOLDOFF completes.
- VALID  out  1  one-cycle pulse: new data published.
- ERR  out  1  one-cycle pulse: read attempt failed.
- ERR_CODE  out  2  01 no response, 10 bit timeout, 11 checksum mismatch; holds until next attempt ends.
- HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC  out  8 each  last good reading.

Behaviour:
- Reset (nRST=0 at an edge):
  - state IDLE, DATA_OE=0, BUSY=0, VALID=0, ERR=0, ERR_CODE=00;
  - all data outputs 0x00; shift register, counters and synchronizer cleared (synchronizer to 1).
  - Reset mid-read releases the bus on that edge; no VALID/ERR is generated.
- DATA_IN goes through a 2-flop synchronizer (preset to 1).
  - rise/fall = change of the synced level vs. its previous value.
  - Bench latency from pad to edge detect: 2 cycles.
- Microsecond timebase:
  - a prescaler emits us_tick every TICKS_PER_US cycles;
  - us_cnt (20 bits) increments on us_tick, saturates at max;
  - prescaler and us_cnt are both cleared on every state entry.
- States:
  - IDLE: DATA_OE=0. START=1 -> START_LOW next cycle, BUSY=1, DATA_OE=1 in that same cycle.
  - START_LOW: DATA_OE=1; us_cnt==START_LOW_US -> RELEASE.
  - RELEASE: DATA_OE=0. fall -> RESP_LOW; us_cnt==TIMEOUT_US -> FAIL(01).
  - RESP_LOW: rise -> RESP_HIGH; timeout -> FAIL(01).
  - RESP_HIGH: fall -> BIT_LOW with bit_idx=0; timeout -> FAIL(01).
  - BIT_LOW: rise -> BIT_HIGH; timeout -> FAIL(10).
  - BIT_HIGH: on fall, bit = (us_cnt > BIT_THRESH_US), shifted into a 40-bit register MSB-first, bit_idx+1.
    - If bit_idx was 39 -> CHECK, else -> BIT_LOW.
    - timeout -> FAIL(10).
  - CHECK (1 cycle): bytes B0..B4 in order received.
    - (B0+B1+B2+B3) mod 256 == B4 -> HUM_INT=B0, HUM_DEC=B1, TEMP_INT=B2, TEMP_DEC=B3, VALID=1, ERR_CODE=00.
    - else ERR=1, ERR_CODE=11, data outputs unchanged.
    - -> HOLDOFF.
  - FAIL (1 cycle): ERR=1, ERR_CODE=code, DATA_OE=0, data unchanged -> HOLDOFF.
  - HOLDOFF: us_cnt==HOLDOFF_US -> IDLE, BUSY=0 on that transition.
- START asserted in any state other than IDLE is ignored (not queued). START held high continuously yields back-to-back reads separated by HOLDOFF.
- A timeout and an edge in the same cycle: the edge wins.
- DATA_OE is 1 only in START_LOW.

Test Plan (TICKS_PER_US=1, START_LOW_US=20, TIMEOUT_US=100, HOLDOFF_US=50):
- Good read: sensor model returns 0x37,0x00,0x19,0x00,0x50 (0-bit high 27 us, 1-bit high 70 us).
  - DATA_OE high exactly 20 us; VALID one pulse.
  - HUM_INT=0x37, TEMP_INT=0x19, ERR never asserts.
  - BUSY drops 50 us after VALID.
- No sensor: DATA_IN tied 1 -> ERR pulse 100 us after release, ERR_CODE=01, data regs keep previous 0x37/0x19, BUSY low 50 us later.
- Checksum error: sensor sends 0x37,0x00,0x19,0x00,0x51 -> ERR, ERR_CODE=11, no VALID, outputs unchanged.
- Bit timeout: sensor stops after 12 bits, line held high -> ERR, ERR_CODE=10, 100 us after the last rise.
- START pulsed during BIT_LOW and during HOLDOFF -> ignored: exactly one VALID, one DATA_OE low pulse.
- nRST=0 for one cycle during START_LOW -> DATA_OE=0 and BUSY=0 on that edge, all data outputs 0x00. A following START performs a full 20 us start pulse.

Source files
------------

// File: rtl/dht11_read_ctrl.sv
// dht11_read_ctrl: read sequencer for the single-wire DHT11 sensor bus.
// Drives the host start pulse, checks the sensor preamble, decodes 40 bits,
// verifies the checksum and publishes humidity/temperature, then holds off.
// Ports:
//   pCLK, nRST         clock, synchronous active-low reset
//   START              read request level, accepted only when idle
//   DATA_IN / DATA_OE  pad level in / 1 = pull bus low
//   BUSY               high from acceptance until hold-off completes
//   VALID / ERR        one-cycle result pulses, ERR_CODE holds last code
//   HUM_*, TEMP_*      last good reading
module dht11_read_ctrl #(
    parameter int unsigned TICKS_PER_US  = 8,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned TIMEOUT_US    = 100,
    parameter int unsigned BIT_THRESH_US = 40,
    parameter int unsigned HOLDOFF_US    = 1000000
) (
    input  logic       pCLK,
    input  logic       nRST,
    input  logic       START,
    input  logic       DATA_IN,
    output logic       DATA_OE,
    output logic       BUSY,
    output logic       VALID,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] HUM_INT,
    output logic [7:0] HUM_DEC,
    output logic [7:0] TEMP_INT,
    output logic [7:0] TEMP_DEC
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_FAIL,
        S_HOLDOFF
    } state_e;

    localparam int unsigned PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_US - 1);
    localparam logic [19:0] START_LOW_C = 20'(START_LOW_US);
    localparam logic [19:0] TIMEOUT_C   = 20'(TIMEOUT_US);
    localparam logic [19:0] THRESH_C    = 20'(BIT_THRESH_US);
    localparam logic [19:0] HOLDOFF_C   = 20'(HOLDOFF_US);

    state_e state_q, state_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [19:0]   us_cnt_q, us_cnt_d, us_inc;
    logic          us_tick;
    logic          tmo;

    // [0] first sync stage, [1] synced level, [2] previous synced level
    logic [2:0] sync_q, sync_d;
    logic       rise, fall;

    logic [39:0] shreg_q, shreg_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  code_q, code_d;
    logic        bit_val;

    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] hum_int_q, hum_int_d;
    logic [7:0] hum_dec_q, hum_dec_d;
    logic [7:0] temp_int_q, temp_int_d;
    logic [7:0] temp_dec_q, temp_dec_d;

    logic [7:0] sum;
    logic       sum_ok;

    assign sync_d = {sync_q[1:0], DATA_IN};
    assign rise   = sync_q[1] & ~sync_q[2];
    assign fall   = ~sync_q[1] & sync_q[2];

    // us_inc is the count as it stands after this cycle's tick, so a
    // compare against N fires exactly N microseconds after state entry.
    always_comb begin
        us_tick = (presc_q == PRESC_LAST);
        us_inc  = us_cnt_q;
        if (us_tick && (us_cnt_q != '1)) begin
            us_inc = us_cnt_q + 20'd1;
        end
        tmo     = (us_inc == TIMEOUT_C);
        bit_val = (us_cnt_q > THRESH_C);
    end

    assign sum    = shreg_q[39:32] + shreg_q[31:24]
                  + shreg_q[23:16] + shreg_q[15:8];
    assign sum_ok = (sum == shreg_q[7:0]);

    // State register
    always_ff @(posedge pCLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an edge takes priority over a timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) state_d = S_START_LOW;
            end
            S_START_LOW: begin
                if (us_inc == START_LOW_C) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (fall)     state_d = S_RESP_LOW;
                else if (tmo) state_d = S_FAIL;
            end
            S_RESP_LOW: begin
                if (rise)     state_d = S_RESP_HIGH;
                else if (tmo) state_d = S_FAIL;
            end
            S_RESP_HIGH: begin
                if (fall)     state_d = S_BIT_LOW;
                else if (tmo) state_d = S_FAIL;
            end
            S_BIT_LOW: begin
                if (rise)     state_d = S_BIT_HIGH;
                else if (tmo) state_d = S_FAIL;
            end
            S_BIT_HIGH: begin
                if (fall) begin
                    state_d = (bit_idx_q == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (tmo) begin
                    state_d = S_FAIL;
                end
            end
            S_CHECK, S_FAIL: begin
                state_d = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (us_inc == HOLDOFF_C) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Timebase restarts on every state change
    always_comb begin
        if (state_d != state_q) begin
            presc_d  = '0;
            us_cnt_d = '0;
        end else begin
            presc_d  = us_tick ? '0 : presc_q + PW'(1);
            us_cnt_d = us_inc;
        end
    end

    // Bit shifter and failure code capture
    always_comb begin
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        code_d    = code_q;
        if (state_q == S_RESP_HIGH && fall) begin
            shreg_d   = '0;
            bit_idx_d = '0;
        end
        if (state_q == S_BIT_HIGH && fall) begin
            shreg_d   = {shreg_q[38:0], bit_val};
            bit_idx_d = bit_idx_q + 6'd1;
        end
        if (state_d == S_FAIL && state_q != S_FAIL) begin
            code_d = (state_q == S_BIT_LOW || state_q == S_BIT_HIGH)
                   ? 2'b10 : 2'b01;
        end
    end

    // Output logic
    always_comb begin
        DATA_OE    = (state_q == S_START_LOW);
        BUSY       = (state_q != S_IDLE);
        valid_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        hum_int_d  = hum_int_q;
        hum_dec_d  = hum_dec_q;
        temp_int_d = temp_int_q;
        temp_dec_d = temp_dec_q;
        if (state_q == S_CHECK) begin
            if (sum_ok) begin
                valid_d    = 1'b1;
                err_code_d = 2'b00;
                hum_int_d  = shreg_q[39:32];
                hum_dec_d  = shreg_q[31:24];
                temp_int_d = shreg_q[23:16];
                temp_dec_d = shreg_q[15:8];
            end else begin
                err_d      = 1'b1;
                err_code_d = 2'b11;
            end
        end
        if (state_q == S_FAIL) begin
            err_d      = 1'b1;
            err_code_d = code_q;
        end
    end

    always_ff @(posedge pCLK) begin
        if (!nRST) begin
            presc_q    <= '0;
            us_cnt_q   <= '0;
            sync_q     <= 3'b111;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            code_q     <= 2'b00;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            hum_int_q  <= 8'h00;
            hum_dec_q  <= 8'h00;
            temp_int_q <= 8'h00;
            temp_dec_q <= 8'h00;
        end else begin
            presc_q    <= presc_d;
            us_cnt_q   <= us_cnt_d;
            sync_q     <= sync_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            hum_int_q  <= hum_int_d;
            hum_dec_q  <= hum_dec_d;
            temp_int_q <= temp_int_d;
            temp_dec_q <= temp_dec_d;
        end
    end

    assign VALID    = valid_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;
    assign HUM_INT  = hum_int_q;
    assign HUM_DEC  = hum_dec_q;
    assign TEMP_INT = temp_int_q;
    assign TEMP_DEC = temp_dec_q;

endmodule

// File: tb/tb_dht11_read_ctrl.sv
// tb_dht11_read_ctrl: directed bench for dht11_read_ctrl with a sensor model
// and a scoreboard of expected VALID/ERR results popped by a monitor.
module tb_dht11_read_ctrl;

    logic       pCLK;
    logic       nRST;
    logic       START;
    logic       DATA_IN;
    logic       DATA_OE;
    logic       BUSY;
    logic       VALID;
    logic       ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] HUM_INT;
    logic [7:0] HUM_DEC;
    logic [7:0] TEMP_INT;
    logic [7:0] TEMP_DEC;

    logic sens;

    dht11_read_ctrl #(
        .TICKS_PER_US (1),
        .START_LOW_US (20),
        .TIMEOUT_US   (100),
        .BIT_THRESH_US(40),
        .HOLDOFF_US   (50)
    ) dut (
        .pCLK    (pCLK),
        .nRST    (nRST),
        .START   (START),
        .DATA_IN (DATA_IN),
        .DATA_OE (DATA_OE),
        .BUSY    (BUSY),
        .VALID   (VALID),
        .ERR     (ERR),
        .ERR_CODE(ERR_CODE),
        .HUM_INT (HUM_INT),
        .HUM_DEC (HUM_DEC),
        .TEMP_INT(TEMP_INT),
        .TEMP_DEC(TEMP_DEC)
    );

    // Open-drain bus: host pulls low, otherwise the sensor (1 = released)
    assign DATA_IN = DATA_OE ? 1'b0 : sens;

    initial pCLK = 1'b0;
    always #5 pCLK = ~pCLK;

    typedef struct packed {
        logic       is_err;
        logic [1:0] code;
        logic [7:0] hi;
        logic [7:0] hd;
        logic [7:0] ti;
        logic [7:0] td;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_pulse_cyc = 0;
    int last_rise_cyc = 0;
    int oe_run = 0;
    int oe_width = 0;
    int oe_rises = 0;
    int rel_cyc = 0;
    int busy_fall_cyc = 0;
    logic oe_prev = 1'b0;
    logic busy_prev = 1'b0;

    always @(posedge pCLK) cyc++;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    function automatic exp_t mk(input logic e, input logic [1:0] c,
                                input logic [7:0] hi, input logic [7:0] ti);
        exp_t r;
        r.is_err = e;
        r.code   = c;
        r.hi     = hi;
        r.hd     = 8'h00;
        r.ti     = ti;
        r.td     = 8'h00;
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge pCLK) begin
        if (nRST && (VALID || ERR)) begin
            last_pulse_cyc = cyc;
            if (VALID) n_valid++;
            if (ERR) n_err++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: VALID=%0b ERR=%0b, none expected",
                         VALID, ERR);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_valid", 32'(VALID), 32'(!mon_e.is_err));
                check("sb_err", 32'(ERR), 32'(mon_e.is_err));
                check("sb_err_code", 32'(ERR_CODE), 32'(mon_e.code));
                check("sb_hum_int", 32'(HUM_INT), 32'(mon_e.hi));
                check("sb_hum_dec", 32'(HUM_DEC), 32'(mon_e.hd));
                check("sb_temp_int", 32'(TEMP_INT), 32'(mon_e.ti));
                check("sb_temp_dec", 32'(TEMP_DEC), 32'(mon_e.td));
            end
        end
    end

    // Bus activity monitor
    always @(negedge pCLK) begin
        if (DATA_OE) oe_run++;
        if (DATA_OE && !oe_prev) oe_rises++;
        if (!DATA_OE && oe_prev) begin
            oe_width = oe_run;
            oe_run   = 0;
            rel_cyc  = cyc;
        end
        if (!BUSY && busy_prev) busy_fall_cyc = cyc;
        oe_prev   = DATA_OE;
        busy_prev = BUSY;
    end

    task automatic us(input int n);
        repeat (n) @(posedge pCLK);
        #1;
    endtask

    task automatic do_start();
        START = 1'b1;
        us(1);
        START = 1'b0;
    endtask

    // which: 0 = DATA_OE, 1 = BUSY
    task automatic wait_sig(input int which, input logic lvl,
                            input int max, input string nm);
        bit   done;
        logic v;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge pCLK);
            v = (which == 0) ? DATA_OE : BUSY;
            if (v == lvl) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s: level %0b not seen within %0d cycles", nm, lvl, max);
        end
        @(posedge pCLK);
        #1;
    endtask

    task automatic wait_valid(input int target, input int max);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge pCLK);
            if (n_valid >= target) done = 1'b1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL wait_valid: count %0d, expected %0d", n_valid, target);
        end
        @(posedge pCLK);
        #1;
    endtask

    // Sensor reply: preamble then nbits of frame MSB-first; optional
    // START pulse in the middle of the low phase of bit poke_bit.
    task automatic sensor_send(input logic [39:0] frame, input int nbits,
                               input int poke_bit);
        logic [39:0] f;
        f = frame;
        sens = 1'b1;
        us(30);
        sens = 1'b0;
        us(80);
        sens = 1'b1;
        us(80);
        for (int i = 0; i < nbits; i++) begin
            sens = 1'b0;
            if (i == poke_bit) begin
                us(25);
                START = 1'b1;
                us(1);
                START = 1'b0;
                us(24);
            end else begin
                us(50);
            end
            sens = 1'b1;
            last_rise_cyc = cyc;
            us(f[39-i] ? 70 : 27);
        end
        sens = 1'b0;
        us(50);
        sens = 1'b1;
        last_rise_cyc = cyc;
    endtask

    task automatic start_and_release();
        do_start();
        wait_sig(0, 1'b1, 10, "oe_rise");
        wait_sig(0, 1'b0, 100, "oe_fall");
    endtask

    int d;
    int v0;
    int r0;

    initial begin
        nRST  = 1'b0;
        START = 1'b0;
        sens  = 1'b1;
        repeat (3) @(posedge pCLK);
        @(negedge pCLK);
        check("rst_data_oe", 32'(DATA_OE), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_valid_err", 32'({VALID, ERR}), 0);
        check("rst_err_code", 32'(ERR_CODE), 0);
        check("rst_data", {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC}, 0);
        @(posedge pCLK);
        #1;
        nRST = 1'b1;
        us(3);

        // Good read
        exp_q.push_back(mk(1'b0, 2'b00, 8'h37, 8'h19));
        start_and_release();
        check("good_oe_width", oe_width, 20);
        sensor_send(40'h37_00_19_00_50, 40, -1);
        wait_sig(1, 1'b0, 300, "good_busy_low");
        check("good_busy_after_valid", busy_fall_cyc - last_pulse_cyc, 50);
        check("good_hum_int", 32'(HUM_INT), 32'h37);
        check("good_temp_int", 32'(TEMP_INT), 32'h19);
        us(5);

        // No sensor
        exp_q.push_back(mk(1'b1, 2'b01, 8'h37, 8'h19));
        start_and_release();
        wait_sig(1, 1'b0, 400, "nosens_busy_low");
        d = last_pulse_cyc - rel_cyc;
        check("nosens_err_delay_100us", 32'(d >= 100 && d <= 102), 1);
        check("nosens_busy_after_err", busy_fall_cyc - last_pulse_cyc, 50);
        us(5);

        // Checksum error
        exp_q.push_back(mk(1'b1, 2'b11, 8'h37, 8'h19));
        start_and_release();
        sensor_send(40'h37_00_19_00_51, 40, -1);
        wait_sig(1, 1'b0, 300, "csum_busy_low");
        us(5);

        // Bit timeout after 12 bits
        exp_q.push_back(mk(1'b1, 2'b10, 8'h37, 8'h19));
        start_and_release();
        sensor_send(40'h37_00_19_00_50, 12, -1);
        wait_sig(1, 1'b0, 400, "bittmo_busy_low");
        d = last_pulse_cyc - last_rise_cyc;
        check("bittmo_err_delay_100us", 32'(d >= 100 && d <= 106), 1);
        us(5);

        // START ignored during BIT_LOW and HOLDOFF
        v0 = n_valid;
        r0 = oe_rises;
        exp_q.push_back(mk(1'b0, 2'b00, 8'h37, 8'h19));
        start_and_release();
        fork
            sensor_send(40'h37_00_19_00_50, 40, 5);
            begin
                wait_valid(v0 + 1, 6000);
                us(10);
                do_start();
            end
        join
        wait_sig(1, 1'b0, 300, "ign_busy_low");
        us(40);
        check("ign_one_start_pulse", oe_rises - r0, 1);
        check("ign_one_valid", n_valid - v0, 1);
        check("ign_still_idle", 32'(BUSY), 0);

        // Reset during START_LOW
        do_start();
        wait_sig(0, 1'b1, 10, "rst_oe_rise");
        us(5);
        nRST = 1'b0;
        @(posedge pCLK);
        #1;
        nRST = 1'b1;
        @(negedge pCLK);
        check("midrst_data_oe", 32'(DATA_OE), 0);
        check("midrst_busy", 32'(BUSY), 0);
        check("midrst_err_code", 32'(ERR_CODE), 0);
        check("midrst_data", {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC}, 0);
        @(posedge pCLK);
        #1;
        us(5);
        exp_q.push_back(mk(1'b0, 2'b00, 8'h37, 8'h19));
        start_and_release();
        check("postrst_oe_width", oe_width, 20);
        sensor_send(40'h37_00_19_00_50, 40, -1);
        wait_sig(1, 1'b0, 300, "postrst_busy_low");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge pCLK);
        check("sb_drained", exp_q.size(), 0);
        check("total_valid", n_valid, 3);
        check("total_err", n_err, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
